// File: rtl/fh_rom_streamer.sv
// Streams runs of consecutive fh_rom words as MSB-first beats on a valid/ready port.
// A one-word prefetch buffer hides the two-cycle ROM fetch behind the current word.
module fh_rom_streamer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 96,
  parameter int OUT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] word_cnt,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  localparam int CHUNKS = DATA_WIDTH / OUT_WIDTH;
  localparam int BEAT_W = $clog2(CHUNKS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CHUNKS - 1);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t                state, next_state;
  logic                  fetch_p0, fetch_p1;
  logic [DATA_WIDTH-1:0] shift_reg, next_buf;
  logic                  next_valid;
  logic [BEAT_W-1:0]     beat;
  logic [ADDR_WIDTH-1:0] fetch_left;
  logic [ADDR_WIDTH-1:0] word_rem;

  logic start_acc, accept, word_end, final_acc;
  logic load_rom, load_buf, to_buf, issue;

  assign out_data = shift_reg[DATA_WIDTH-1 -: OUT_WIDTH];
  assign out_last = out_valid && (word_rem == '0) && (beat == LAST_BEAT);

  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    start_acc  = 1'b0;
    load_rom   = 1'b0;
    load_buf   = 1'b0;
    to_buf     = 1'b0;
    accept     = out_valid && out_ready;
    word_end   = accept && (beat == LAST_BEAT);
    final_acc  = word_end && (word_rem == '0);
    case (state)
      IDLE: begin
        if (start) begin
          start_acc  = 1'b1;
          next_state = FILL;
        end
      end
      FILL: begin
        if (fetch_p1) begin
          load_rom   = 1'b1;
          next_state = STREAM;
        end
      end
      STREAM: begin
        // A capture goes straight to the shift register only if that register is idle this edge.
        if (fetch_p1) begin
          if (!out_valid || (word_end && !next_valid)) load_rom = 1'b1;
          else                                         to_buf   = 1'b1;
        end
        load_buf = word_end && next_valid;
        if (final_acc) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    issue = (load_rom || load_buf) && (fetch_left != '0);
  end

  // Stage p0: address presented to ROM; stage p1: ROM word available for capture
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      fetch_p0   <= 1'b0;
      fetch_p1   <= 1'b0;
      rom_addr   <= '0;
      fetch_left <= '0;
      word_rem   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      shift_reg  <= '0;
      beat       <= '0;
      next_buf   <= '0;
      next_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      fetch_p0 <= start_acc || issue;
      fetch_p1 <= fetch_p0;
      done     <= final_acc;

      if (start_acc) begin
        rom_addr   <= start_addr;
        fetch_left <= word_cnt;
        word_rem   <= word_cnt;
        busy       <= 1'b1;
        next_valid <= 1'b0;
      end else begin
        if (issue) begin
          rom_addr   <= rom_addr + 1'b1;
          fetch_left <= fetch_left - 1'b1;
        end
        if (final_acc) busy <= 1'b0;
        if ((load_rom || load_buf) && (state == STREAM)) word_rem <= word_rem - 1'b1;
        if (to_buf) begin
          next_buf   <= rom_rd_data;
          next_valid <= 1'b1;
        end else if (load_buf) begin
          next_valid <= 1'b0;
        end
      end

      if (load_rom) begin
        shift_reg <= rom_rd_data;
        beat      <= '0;
      end else if (load_buf) begin
        shift_reg <= next_buf;
        beat      <= '0;
      end else if (accept) begin
        shift_reg <= shift_reg << OUT_WIDTH;
        beat      <= beat + 1'b1;
      end

      if (load_rom || load_buf) out_valid <= 1'b1;
      else if (word_end)        out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fh_rom_streamer.sv
// Bench for fh_rom_streamer: ROM model plus a byte-queue reference built from ROM contents.
// Directed runs with random ROM data and random backpressure.
module tb_fh_rom_streamer;
  logic        clk, tb_rst, start, busy, done, out_valid, out_ready, out_last;
  logic [7:0]  start_addr, word_cnt, rom_addr, out_data;
  logic [95:0] rom_rd_data;
  logic [95:0] mem [256];
  int checks = 0;
  int errors = 0;

  fh_rom_streamer #(.ADDR_WIDTH(8), .DATA_WIDTH(96), .OUT_WIDTH(8)) dut (
    .clk(clk), .tb_rst(tb_rst), .start(start), .start_addr(start_addr),
    .word_cnt(word_cnt), .busy(busy), .done(done), .rom_addr(rom_addr),
    .rom_rd_data(rom_rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_rd_data <= mem[rom_addr];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 five-cycle stall at beat 6 then random
  task automatic run(input logic [7:0] sa, input int wc, input int rmode,
                     input int ign_beat, input int rst_beat);
    logic [7:0]  exp_q[$];
    logic [7:0]  addr_q[$];
    logic [95:0] w;
    logic [7:0]  held, last_a;
    logic        stalled, held_last, r, fin;
    int idx, cyc, first_cyc, total, limit, stall_left;
    for (int i = 0; i <= wc; i++) begin
      w = mem[8'(sa + i)];
      for (int k = 0; k < 12; k++) exp_q.push_back(w[95-8*k -: 8]);
    end
    total = exp_q.size();
    limit = (rmode == 0) ? total + 10 : 8 * total + 60;
    start = 1'b1; start_addr = sa; word_cnt = 8'(wc);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("valid_after_start", out_valid, 1'b0);
    chk("rom_addr_first", rom_addr, sa);
    chk("done_cleared", done, 1'b0);
    addr_q.push_back(rom_addr); last_a = rom_addr;
    idx = 0; cyc = 0; first_cyc = -1; fin = 1'b0; stalled = 1'b0;
    held = '0; held_last = 1'b0; stall_left = 5;
    while (!fin && cyc < limit) begin
      start = 1'b0;
      if (rst_beat >= 0 && idx == rst_beat) begin
        tb_rst = 1'b1; #1;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'h00);
        chk("rst_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", rom_addr, 8'h00);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk("rst_hold_done", done, 1'b0);
          chk("rst_hold_valid", out_valid, 1'b0);
        end
        tb_rst = 1'b0;
        out_ready = 1'b0;
        return;
      end
      chk("done_mid_run", done, 1'b0);
      if (rmode == 0) r = 1'b1;
      else if (rmode == 2 && idx == 6 && stall_left > 0 && out_valid) begin
        r = 1'b0; stall_left--;
      end else r = 1'($urandom_range(0, 1));
      out_ready = r;
      if (stalled) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, held);
        chk("stall_last", out_last, held_last);
      end
      if (out_valid && idx < total) begin
        if (first_cyc < 0) first_cyc = cyc;
        chk("beat_data", out_data, exp_q[idx]);
        chk("beat_last", out_last, (idx == total - 1));
        stalled = !r; held = out_data; held_last = out_last;
        if (r) begin
          idx++;
          if (idx == total) fin = 1'b1;
        end
      end else begin
        stalled = 1'b0;
        chk("idle_last", out_last, 1'b0);
      end
      if (ign_beat >= 0 && idx == ign_beat && out_valid) begin
        start = 1'b1; start_addr = 8'h20; word_cnt = 8'h00;
        ign_beat = -1;
      end
      @(posedge clk); #1;
      cyc++;
      if (rom_addr !== last_a) begin
        addr_q.push_back(rom_addr); last_a = rom_addr;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk("run_completed", fin, 1'b1);
    chk("beats_delivered", idx, total);
    chk("first_beat_latency", first_cyc, 2);
    if (rmode == 0) chk("gap_free", cyc, total + 2);
    chk("end_valid", out_valid, 1'b0);
    chk("end_last", out_last, 1'b0);
    chk("end_busy", busy, 1'b0);
    chk("end_done", done, 1'b1);
    if (wc <= 3) begin
      chk("addr_count", addr_q.size(), wc + 1);
      for (int i = 0; i < addr_q.size() && i <= wc; i++)
        chk("addr_seq", addr_q[i], 8'(sa + i));
    end
  endtask

  initial begin
    tb_rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    start_addr = '0; word_cnt = '0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom};
    mem[8'h10] = 96'h0102030405060708090A0B0C;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_data", out_data, 8'h00);
    chk("reset_last", out_last, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_addr", rom_addr, 8'h00);
    tb_rst = 1'b0;
    @(posedge clk); #1;

    run(8'h10, 0, 0, -1, -1);
    run(8'h10, 3, 0, -1, -1);
    run(8'hFE, 3, 1, -1, -1);
    run(8'h40, 5, 2, -1, -1);
    run(8'h50, 2, 0, 5, -1);
    run(8'h60, 4, 1, -1, 20);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) mem[i] = '1;
    run(8'h00, 255, 0, -1, -1);
    @(posedge clk); #1;
    chk("final_done_drop", done, 1'b0);
    chk("final_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
